// File: rtl/chan_reconfig_pkg.sv
// chan_reconfig_pkg: state encoding, shared constants and FFT size legality check for the channelizer reconfiguration sequencer
package chan_reconfig_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GATE      = 3'd1,
        DRAIN     = 3'd2,
        LOAD_COEF = 3'd3,
        LOAD_MASK = 3'd4,
        COMMIT    = 3'd5
    } state_t;
    localparam int MAX_FFT_SIZE       = 2048;
    localparam int TAPS_PER_PHASE     = 32;
    localparam int MASK_BITS_PER_WORD = 32;
    function automatic logic legal_size(input logic [31:0] n, input int lo, input int hi);
        return n != 0 && (n & (n - 32'd1)) == 0 && n >= 32'(lo) && n <= 32'(hi);
    endfunction
endpackage

// File: rtl/chan_reconfig_if.sv
// chan_reconfig_if: 32-bit AXI-Stream link used for the sample, coefficient, mask, reload and select buses
// master drives tdata/tlast/tvalid and samples tready; slave is the mirror image.
interface chan_reconfig_if;
    logic [31:0] tdata;
    logic        tlast;
    logic        tvalid;
    logic        tready;
    modport master (output tdata, tlast, tvalid, input tready);
    modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/chan_reconfig_beat_cnt.sv
// chan_reconfig_beat_cnt: gated AXIS pass-through that stops after n_beats handshakes and generates its own tlast
// ce_clk/ce_rst_n : clock, async active-low reset
// en              : load window open; outside it both valid and ready are forced low
// n_beats         : terminal beat count (>= 1)
// src / dst       : source stream in, forwarded stream out
// done            : pulses on the final handshake
// len_err         : pulses when the source tlast disagrees with the beat count on a handshake
module chan_reconfig_beat_cnt (
    input  logic                   ce_clk,
    input  logic                   ce_rst_n,
    input  logic                   en,
    input  logic [16:0]            n_beats,
    chan_reconfig_if.slave         src,
    chan_reconfig_if.master        dst,
    output logic                   done,
    output logic                   len_err
);
    logic [16:0] cnt;
    logic        last;
    logic        hs;
    assign last       = cnt == n_beats - 17'd1;
    assign dst.tdata  = src.tdata;
    assign dst.tlast  = en & last;
    assign dst.tvalid = en & src.tvalid;
    assign src.tready = en & dst.tready;
    assign hs         = dst.tvalid & dst.tready;
    assign done       = hs & last;
    // the count is authoritative; a disagreeing source tlast is only flagged
    assign len_err    = hs & (src.tlast ^ last);
    always_ff @(posedge ce_clk or negedge ce_rst_n)
        if (!ce_rst_n) cnt <= '0;
        else           cnt <= (!en || done) ? '0 : cnt + {16'd0, hs};
endmodule

// File: rtl/chan_reconfig_ctrl.sv
// chan_reconfig_ctrl: run-time FFT size reconfiguration sequencer for the M2 channelizer
// ce_clk/ce_rst_n        : clock, async active-low reset
// cfg_*                  : FFT size request handshake
// s_data / m_data        : sample stream, gated at packet boundaries
// mon_out_tvalid         : channelizer output activity, used to detect an empty pipeline
// s_coef / m_reload      : coefficient source and channelizer reload bus
// s_mask / m_select      : mask source and channelizer select bus
// fft_size/fft_size_stb  : committed size and its one-cycle commit strobe
// busy/state_rb          : status readback
// err_cfg/err_len        : rejected-request pulse, sticky load length error
module chan_reconfig_ctrl
    import chan_reconfig_pkg::*;
#(
    parameter int FFT_W          = 12,
    parameter int MAX_FFT_SIZE   = 2048,
    parameter int MIN_FFT_SIZE   = 8,
    parameter int TAPS_PER_PHASE = 32,
    parameter int DRAIN_CYCLES   = 64,
    parameter int RESET_FFT_SIZE = 2048
) (
    input  logic             ce_clk,
    input  logic             ce_rst_n,
    input  logic [FFT_W-1:0] cfg_fft_size,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    chan_reconfig_if.slave   s_data,
    chan_reconfig_if.master  m_data,
    input  logic             mon_out_tvalid,
    chan_reconfig_if.slave   s_coef,
    chan_reconfig_if.master  m_reload,
    chan_reconfig_if.slave   s_mask,
    chan_reconfig_if.master  m_select,
    output logic [FFT_W-1:0] fft_size,
    output logic             fft_size_stb,
    output logic             busy,
    output logic [2:0]       state_rb,
    output logic             err_cfg,
    output logic             err_len
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    state_t           state;
    state_t           state_n;
    logic             mid_pkt;
    logic             pass;
    logic             accept;
    logic             coef_done;
    logic             mask_done;
    logic             coef_err;
    logic             mask_err;
    logic [FFT_W-1:0] pend_size;
    logic [CW-1:0]    idle_cnt;
    logic [16:0]      n_coef;
    logic [16:0]      n_mask;
    assign accept       = cfg_valid && state == IDLE &&
                          legal_size(32'(cfg_fft_size), MIN_FFT_SIZE, MAX_FFT_SIZE);
    assign err_cfg      = cfg_valid && state == IDLE && !accept;
    assign cfg_ready    = state == IDLE;
    assign busy         = state != IDLE;
    assign state_rb     = state;
    assign fft_size_stb = state == COMMIT;
    // GATE only lets the packet already in flight finish
    assign pass          = state == IDLE || (state == GATE && mid_pkt);
    assign m_data.tdata  = s_data.tdata;
    assign m_data.tlast  = s_data.tlast;
    assign m_data.tvalid = s_data.tvalid & pass;
    assign s_data.tready = m_data.tready & pass;
    assign n_coef = 17'(pend_size) * 17'(TAPS_PER_PHASE);
    assign n_mask = (pend_size < FFT_W'(MASK_BITS_PER_WORD)) ? 17'd1 :
                    17'(pend_size / FFT_W'(MASK_BITS_PER_WORD));
    chan_reconfig_beat_cnt u_coef (
        .ce_clk   (ce_clk),
        .ce_rst_n (ce_rst_n),
        .en       (state == LOAD_COEF),
        .n_beats  (n_coef),
        .src      (s_coef),
        .dst      (m_reload),
        .done     (coef_done),
        .len_err  (coef_err)
    );
    chan_reconfig_beat_cnt u_mask (
        .ce_clk   (ce_clk),
        .ce_rst_n (ce_rst_n),
        .en       (state == LOAD_MASK),
        .n_beats  (n_mask),
        .src      (s_mask),
        .dst      (m_select),
        .done     (mask_done),
        .len_err  (mask_err)
    );
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = accept ? GATE : IDLE;
            GATE:      state_n = mid_pkt ? GATE : DRAIN;
            DRAIN:     state_n = (!mon_out_tvalid && idle_cnt == CW'(DRAIN_CYCLES - 1)) ? LOAD_COEF : DRAIN;
            LOAD_COEF: state_n = coef_done ? LOAD_MASK : LOAD_COEF;
            LOAD_MASK: state_n = mask_done ? COMMIT : LOAD_MASK;
            COMMIT:    state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge ce_clk or negedge ce_rst_n)
        if (!ce_rst_n) state <= IDLE;
        else           state <= state_n;
    always_ff @(posedge ce_clk or negedge ce_rst_n)
        if (!ce_rst_n) begin
            mid_pkt   <= 1'b0;
            pend_size <= FFT_W'(RESET_FFT_SIZE);
            idle_cnt  <= '0;
            fft_size  <= FFT_W'(RESET_FFT_SIZE);
            err_len   <= 1'b0;
        end else begin
            if (s_data.tvalid && s_data.tready) mid_pkt <= !s_data.tlast;
            if (accept) pend_size <= cfg_fft_size;
            // zero outside DRAIN, so DRAIN always starts counting from zero
            idle_cnt <= (state == DRAIN && !mon_out_tvalid) ? idle_cnt + 1'b1 : '0;
            if (state == COMMIT) fft_size <= pend_size;
            err_len <= !accept && (err_len || coef_err || mask_err);
        end
endmodule

// File: tb/tb_chan_reconfig_ctrl.sv
// tb_chan_reconfig_ctrl: scoreboard bench for the channelizer reconfiguration sequencer
module tb_chan_reconfig_ctrl;
    localparam int FW = 13;
    logic          ce_clk = 1'b0;
    logic          ce_rst_n = 1'b0;
    logic [FW-1:0] cfg_fft_size = '0;
    logic          cfg_valid = 1'b0;
    logic          mon_out_tvalid = 1'b0;
    logic          cfg_ready;
    logic          fft_size_stb;
    logic          busy;
    logic          err_cfg;
    logic          err_len;
    logic [FW-1:0] fft_size;
    logic [2:0]    state_rb;
    chan_reconfig_if s_data();
    chan_reconfig_if m_data();
    chan_reconfig_if s_coef();
    chan_reconfig_if m_reload();
    chan_reconfig_if s_mask();
    chan_reconfig_if m_select();
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   c_idx = 0;
    int   c_n = 0;
    int   c_bad = -1;
    int   m_idx = 0;
    int   m_n = 0;
    int   rl_cnt = 0;
    int   sl_cnt = 0;
    int   req_cyc = 0;
    int   stb_cyc = 0;
    int   gate_viol = 0;
    int   n_errcfg = 0;
    logic m_hold = 1'b0;
    logic stall_en = 1'b0;
    logic c_hs = 1'b0;
    logic m_hs = 1'b0;
    logic [32:0] rl_q[$];
    logic [32:0] sl_q[$];

    chan_reconfig_ctrl #(.FFT_W(FW)) dut (
        .ce_clk         (ce_clk),
        .ce_rst_n       (ce_rst_n),
        .cfg_fft_size   (cfg_fft_size),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .s_data         (s_data),
        .m_data         (m_data),
        .mon_out_tvalid (mon_out_tvalid),
        .s_coef         (s_coef),
        .m_reload       (m_reload),
        .s_mask         (s_mask),
        .m_select       (m_select),
        .fft_size       (fft_size),
        .fft_size_stb   (fft_size_stb),
        .busy           (busy),
        .state_rb       (state_rb),
        .err_cfg        (err_cfg),
        .err_len        (err_len)
    );

    always #5 ce_clk = ~ce_clk;
    always @(posedge ce_clk) cyc++;

    assign s_coef.tdata  = 32'hC000_0000 | 32'(c_idx);
    assign s_coef.tvalid = c_idx < c_n;
    assign s_coef.tlast  = c_idx == c_n - 1 || c_idx == c_bad;
    assign s_mask.tdata  = 32'h5E00_0000 | 32'(m_idx);
    assign s_mask.tvalid = m_idx < m_n && !m_hold;
    assign s_mask.tlast  = m_idx == m_n - 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // handshakes are decided at the negedge, where every input is stable for the coming posedge
    always @(negedge ce_clk) begin
        c_hs = s_coef.tvalid && s_coef.tready;
        m_hs = s_mask.tvalid && s_mask.tready;
        if (c_hs) rl_q.push_back({c_idx == c_n - 1, s_coef.tdata});
        if (m_hs) sl_q.push_back({m_idx == m_n - 1, s_mask.tdata});
        if (m_reload.tvalid && m_reload.tready) begin
            rl_cnt++;
            if (rl_q.size() == 0) check("reload_unexpected", m_reload.tvalid, 0);
            else check("reload_beat", {m_reload.tlast, m_reload.tdata}, rl_q.pop_front());
        end
        if (m_select.tvalid && m_select.tready) begin
            sl_cnt++;
            if (sl_q.size() == 0) check("select_unexpected", m_select.tvalid, 0);
            else check("select_beat", {m_select.tlast, m_select.tdata}, sl_q.pop_front());
        end
        if (err_cfg) n_errcfg++;
    end

    initial begin
        m_reload.tready = 1'b1;
        m_select.tready = 1'b1;
        forever begin
            @(posedge ce_clk);
            #1;
            if (c_hs) c_idx++;
            if (m_hs) m_idx++;
            m_reload.tready = stall_en ? $urandom_range(0, 3) != 0 : 1'b1;
            m_select.tready = stall_en ? $urandom_range(0, 3) != 0 : 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge ce_clk);
        #1;
    endtask

    task automatic req(input int size);
        cfg_fft_size = FW'(size);
        cfg_valid = 1'b1;
        req_cyc = cyc;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic arm(input int size, input int bad);
        c_idx = 0;
        c_n = size * 32;
        c_bad = bad;
        m_idx = 0;
        m_n = size < 32 ? 1 : size / 32;
        rl_cnt = 0;
        sl_cnt = 0;
    endtask

    task automatic wait_stb(input int budget);
        int n = 0;
        gate_viol = 0;
        do begin
            @(negedge ce_clk);
            n++;
            if (s_data.tready || m_data.tvalid) gate_viol++;
        end while (!fft_size_stb && n < budget);
        check("stb_seen", fft_size_stb, 1);
        stb_cyc = cyc;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget);
        int n = 0;
        do begin
            @(negedge ce_clk);
            n++;
        end while (state_rb != st && n < budget);
        check("state_reached", state_rb, st);
    endtask

    task automatic post_commit(input int size);
        tick();
        check("commit_fft_size", fft_size, size);
        check("commit_state", state_rb, 0);
        check("commit_stb_single", fft_size_stb, 0);
        check("commit_cfg_ready", cfg_ready, 1);
        check("reload_count", rl_cnt, c_n);
        check("select_count", sl_cnt, m_n);
        check("reload_q_empty", rl_q.size(), 0);
        check("select_q_empty", sl_q.size(), 0);
        check("gate_closed_while_busy", gate_viol, 0);
    endtask

    initial begin
        s_data.tvalid = 1'b0;
        s_data.tdata = '0;
        s_data.tlast = 1'b0;
        m_data.tready = 1'b1;
        tick(3);
        check("rst_state_hold", state_rb, 0);
        ce_rst_n = 1'b1;
        tick();
        check("rst_fft_size", fft_size, 2048);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_err_len", err_len, 0);
        check("rst_stb", fft_size_stb, 0);
        check("rst_coef_tready", s_coef.tready, 0);
        check("rst_reload_tvalid", m_reload.tvalid, 0);
        check("rst_data_tready", s_data.tready, 1);

        s_data.tdata = 32'hA5A5_0001;
        s_data.tvalid = 1'b1;
        #1;
        check("pass_tdata", m_data.tdata, 32'hA5A5_0001);
        check("pass_tvalid", m_data.tvalid, 1);
        tick();
        s_data.tdata = 32'hA5A5_0002;
        s_data.tlast = 1'b1;
        #1;
        check("pass_tdata_last", m_data.tdata, 32'hA5A5_0002);
        tick();
        s_data.tvalid = 1'b0;
        s_data.tlast = 1'b0;

        cfg_fft_size = FW'(300);
        cfg_valid = 1'b1;
        #1;
        check("err_cfg_300", err_cfg, 1);
        tick();
        cfg_valid = 1'b0;
        #1;
        check("err_cfg_300_state", state_rb, 0);
        check("err_cfg_300_clear", err_cfg, 0);
        cfg_fft_size = FW'(4096);
        cfg_valid = 1'b1;
        #1;
        check("err_cfg_4096", err_cfg, 1);
        tick();
        cfg_valid = 1'b0;
        #1;
        check("err_cfg_4096_state", state_rb, 0);
        check("err_cfg_4096_busy", busy, 0);
        check("err_cfg_pulses", n_errcfg, 2);

        stall_en = 1'b1;
        arm(256, -1);
        s_data.tvalid = 1'b1;
        s_data.tdata = 32'h0000_00D0;
        tick();
        s_data.tdata = 32'h0000_00D1;
        req(256);
        check("gate_state", state_rb, 1);
        check("gate_busy", busy, 1);
        check("gate_cfg_ready", cfg_ready, 0);
        s_data.tdata = 32'h0000_00D2;
        #1;
        check("gate_mid_tready", s_data.tready, 1);
        check("gate_mid_tdata", m_data.tdata, 32'h0000_00D2);
        tick();
        s_data.tdata = 32'h0000_00D3;
        s_data.tlast = 1'b1;
        #1;
        check("gate_last_tready", s_data.tready, 1);
        tick();
        s_data.tdata = 32'h0000_00E0;
        #1;
        check("gate_closed_tready", s_data.tready, 0);
        check("gate_closed_tvalid", m_data.tvalid, 0);
        wait_stb(30000);
        post_commit(256);
        check("resume_tvalid", m_data.tvalid, 1);
        check("resume_tready", s_data.tready, 1);
        check("resume_tdata", m_data.tdata, 32'h0000_00E0);
        check("clean_err_len", err_len, 0);
        tick();
        s_data.tvalid = 1'b0;
        s_data.tlast = 1'b0;
        stall_en = 1'b0;
        tick(2);

        arm(8, -1);
        req(8);
        wait_stb(2000);
        check("latency_8", stb_cyc - req_cyc + 1, 1 + 1 + 64 + 256 + 1 + 1);
        post_commit(8);
        check("size8_err_len", err_len, 0);

        arm(16, -1);
        req(16);
        tick(41);
        check("drain_before_pulse", state_rb, 2);
        mon_out_tvalid = 1'b1;
        tick();
        mon_out_tvalid = 1'b0;
        tick(63);
        check("drain_hold_64", state_rb, 2);
        tick();
        check("drain_restart_load", state_rb, 3);
        wait_stb(2000);
        post_commit(16);

        arm(256, 99);
        req(256);
        wait_state(3'd4, 20000);
        check("err_len_set", err_len, 1);
        wait_stb(2000);
        post_commit(256);
        check("err_len_sticky", err_len, 1);

        m_hold = 1'b1;
        arm(64, 5);
        req(64);
        check("err_len_cleared", err_len, 0);
        wait_state(3'd4, 5000);
        tick(3);
        check("hold_in_mask", state_rb, 4);
        check("hold_err_len", err_len, 1);
        ce_rst_n = 1'b0;
        #1;
        check("arst_state", state_rb, 0);
        check("arst_fft_size", fft_size, 2048);
        check("arst_busy", busy, 0);
        check("arst_cfg_ready", cfg_ready, 1);
        check("arst_err_len", err_len, 0);
        check("arst_stb", fft_size_stb, 0);
        check("arst_mask_tready", s_mask.tready, 0);
        check("arst_select_tvalid", m_select.tvalid, 0);
        check("arst_data_tready", s_data.tready, 1);
        tick();
        ce_rst_n = 1'b1;
        m_hold = 1'b0;
        arm(0, -1);
        tick(2);
        check("post_rst_idle", state_rb, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
